mem_store_bridge: RTL

Downstream consumer of the core's store port (mem_addr/mem_data/mem_we), which is word-addressed, one store per cycle, with no stall input.
Decodes each store into one of three targets: on-chip data RAM, an LED register, or a buffered 8N1 UART transmitter.
It must never back-pressure the core: stores are always accepted or dropped within the same cycle.
Sits between core and board pins.

---
 rtl/mem_store_bridge_pkg.sv | 39 +++
 rtl/mem_store_bridge_if.sv | 9 +
 rtl/mem_store_bridge_uart_tx_fsm.sv | 115 +++++++++++
 rtl/mem_store_bridge.sv | 119 +++++++++++
 4 files changed

// File: rtl/mem_store_bridge_pkg.sv
// Shared definitions for the store bridge.
// Holds the peripheral address map, the store target decode and the UART TX state encoding.
package mem_store_bridge_pkg;

  // Peripheral word addresses (word-addressed store port)
  localparam logic [31:0] ADDR_LED  = 32'h8000_0000;
  localparam logic [31:0] ADDR_UART = 32'h8000_0001;
  localparam logic [31:0] ADDR_UCLR = 32'h8000_0002;

  // UART transmitter states, 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Which target a store hits; at most one per cycle
  typedef enum logic [2:0] {
    TGT_NONE = 3'd0,
    TGT_RAM  = 3'd1,
    TGT_LED  = 3'd2,
    TGT_UART = 3'd3,
    TGT_UCLR = 3'd4
  } store_tgt_e;

  // Map a store address to its target. RAM occupies every address whose
  // bits above the RAM index are all zero; anything unmapped is dropped.
  function automatic store_tgt_e decode_target(input logic [31:0] addr, input int ram_aw);
    store_tgt_e tgt;
    tgt = TGT_NONE;
    if ((addr >> ram_aw) == 32'd0) tgt = TGT_RAM;
    else if (addr == ADDR_LED)     tgt = TGT_LED;
    else if (addr == ADDR_UART)    tgt = TGT_UART;
    else if (addr == ADDR_UCLR)    tgt = TGT_UCLR;
    return tgt;
  endfunction

endpackage

// File: rtl/mem_store_bridge_if.sv
// Core store port: one word-addressed store per cycle, no stall.
interface mem_store_bridge_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_we;

  modport master (output mem_addr, output mem_data, output mem_we);
  modport slave  (input  mem_addr, input  mem_data, input  mem_we);
endinterface

// File: rtl/mem_store_bridge_uart_tx_fsm.sv
// 8N1 serial transmitter. Pulls bytes from an external FIFO through a
// valid/pop pair and chains frames without an idle gap when more data waits.
module mem_store_bridge_uart_tx_fsm
  import mem_store_bridge_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       pop,
  output logic       tx,
  output logic       idle
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_e         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              baud_last;

  assign baud_last = (baud_q == BAUD_LAST);

  // Next-state, counters, FIFO pop and registered-line value
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (in_valid) begin
          pop     = 1'b1;
          shift_d = in_data;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          // Chain straight into the next start bit when data is waiting
          if (in_valid) begin
            pop     = 1'b1;
            shift_d = in_data;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line level follows the state being entered so tx stays aligned with it
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  // State registers; reset aborts any frame and parks the line high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign tx   = tx_q;
  assign idle = (state_q == ST_IDLE);

endmodule

// File: rtl/mem_store_bridge.sv
// Store-port sink: decodes each store to data RAM, LED register or UART TX FIFO.
// Every store is accepted or dropped in the cycle it appears; the core never stalls.
module mem_store_bridge
  import mem_store_bridge_pkg::*;
#(
  parameter int RAM_AW       = 8,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_store_bridge_if.slave mem,
  input  logic [RAM_AW-1:0] dbg_addr,
  output logic [31:0]       dbg_rdata,
  output logic [15:0]       led,
  output logic              uart_tx,
  output logic              tx_busy,
  output logic              tx_overflow
);

  localparam int RAM_WORDS = 1 << RAM_AW;
  localparam int FIFO_AW   = $clog2(FIFO_DEPTH);
  localparam int PTR_W     = FIFO_AW + 1;

  store_tgt_e tgt;

  // Store decode; nothing is targeted without the strobe
  always_comb begin
    tgt = TGT_NONE;
    if (mem.mem_we) tgt = decode_target(mem.mem_addr, RAM_AW);
  end

  // ---------------- data RAM ----------------
  logic [31:0] ram [0:RAM_WORDS-1];
  logic [31:0] dbg_rdata_q, dbg_rdata_d;

  // RAM write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (tgt == TGT_RAM) ram[mem.mem_addr[RAM_AW-1:0]] <= mem.mem_data;
  end

  // Debug read; sampling before the write lands gives read-before-write
  always_comb dbg_rdata_d = ram[dbg_addr];

  // ---------------- UART TX FIFO ----------------
  logic [7:0]       fifo_mem [0:FIFO_DEPTH-1];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             fifo_empty, fifo_full;
  logic             push_req, push_ok, pop;
  logic [7:0]       fifo_head;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                      (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign fifo_head  = fifo_mem[rd_ptr_q[FIFO_AW-1:0]];
  assign push_req   = (tgt == TGT_UART);
  // A full FIFO still takes the byte if the transmitter frees a slot this cycle
  assign push_ok    = push_req && (!fifo_full || pop);

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q[FIFO_AW-1:0]] <= mem.mem_data[7:0];
  end

  // ---------------- registers ----------------
  logic [15:0] led_q, led_d;
  logic        ovf_q, ovf_d;

  // Pointer advance, LED update and sticky overflow flag
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    led_d    = led_q;
    ovf_d    = ovf_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (tgt == TGT_LED) led_d = mem.mem_data[15:0];
    if (tgt == TGT_UCLR)              ovf_d = 1'b0;
    else if (push_req && !push_ok)    ovf_d = 1'b1;
  end

  // Control state; reset empties the FIFO and clears all visible outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      led_q       <= '0;
      ovf_q       <= 1'b0;
      dbg_rdata_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      led_q       <= led_d;
      ovf_q       <= ovf_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  // ---------------- transmitter ----------------
  logic fsm_idle;

  mem_store_bridge_uart_tx_fsm #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_valid(!fifo_empty),
    .in_data (fifo_head),
    .pop     (pop),
    .tx      (uart_tx),
    .idle    (fsm_idle)
  );

  assign dbg_rdata   = dbg_rdata_q;
  assign led         = led_q;
  assign tx_overflow = ovf_q;
  assign tx_busy     = !fsm_idle || !fifo_empty;

endmodule
